cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter_pkg.sv | 37 +++
 rtl/cacheline_adapter.sv | 136 +++++++++++++
 tb/tb_cacheline_adapter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared widths, state encoding and line/address helpers for the cacheline adapter,
// which bridges 256-bit cache line requests onto a 64-bit burst memory port.
package cacheline_adapter_pkg;

  localparam int ADDR_BITS   = 32;
  localparam int LINE_BITS   = 256;
  localparam int BEAT_BITS   = 64;
  localparam int BEATS       = 4;
  localparam int CNT_BITS    = 2;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    RESP
  } state_e;

  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  // Lines are 32-byte aligned, so the byte offset within a line is dropped.
  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
    return {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  function automatic logic [BEAT_BITS-1:0] line_beat(input logic [LINE_BITS-1:0] line,
                                                     input logic [CNT_BITS-1:0]  idx);
    logic [BEAT_BITS-1:0] beat;
    beat = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (idx == CNT_BITS'(k)) beat = line[k*BEAT_BITS +: BEAT_BITS];
    end
    return beat;
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Cache line adapter: serialises a 256-bit writeback into four 64-bit beats and
// assembles four tagged 64-bit read beats into a 256-bit fill line.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic [ADDR_BITS-1:0] bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [ADDR_BITS-1:0] bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LINE_BITS-1:0]  wline_q, wline_d;
  logic [LINE_BITS-1:0]  rline_q, rline_d;
  logic                  beat_hit;

  // Only beats tagged with our line address belong to this fill.
  assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_write)     state_d = WRITE;
        else if (dfp_read) state_d = READ_REQ;
      end
      WRITE: begin
        if (bmem_ready && (cnt_q == LAST_BEAT)) state_d = RESP;
      end
      READ_REQ: begin
        if (bmem_ready) state_d = READ_WAIT;
      end
      READ_WAIT: begin
        if (beat_hit && (cnt_q == LAST_BEAT)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: latch the request on IDLE exit, then step one beat per accepted transfer.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_write) begin
          addr_d  = line_align(dfp_addr);
          wline_d = dfp_wdata;
          rline_d = '0;
          cnt_d   = '0;
        end else if (dfp_read) begin
          addr_d  = line_align(dfp_addr);
          rline_d = '0;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (bmem_ready) cnt_d = cnt_q + 1'b1;
      end
      READ_WAIT: begin
        if (beat_hit) begin
          for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_BITS'(k)) rline_d[k*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    dfp_resp   = 1'b0;
    dfp_rdata  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    unique case (state_q)
      WRITE: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_beat(wline_q, cnt_q);
      end
      READ_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      READ_WAIT: begin
        bmem_addr = addr_q;
      end
      // rline_q is cleared on every acceptance, so a writeback responds with zeros.
      RESP: begin
        dfp_resp  = 1'b1;
        dfp_rdata = rline_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus pushes expected beats, commands
// and responses into queues; a negedge monitor pops and compares what the DUT presents.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0;
  logic         dfp_write = 1'b0;
  logic [255:0] dfp_wdata = '0;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b1;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  logic         ready_toggle = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [95:0]  wq[$];
  logic [31:0]  cq[$];
  logic [255:0] rq[$];

  logic [95:0]  exp_w;
  logic [31:0]  exp_c;
  logic [255:0] exp_r;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got an unexpected transfer expected none", name);
  endtask

  // Memory-side ready: either held high or toggled every cycle, updated just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bmem_ready = ready_toggle ? ~bmem_ready : 1'b1;
    end
  end

  // Monitor: every accepted beat/command and every response must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bmem_write && bmem_ready) begin
        if (wq.size() == 0) reportUnexpected("write_beat");
        else begin
          exp_w = wq.pop_front();
          checkOutput("write_addr", 256'(bmem_addr), 256'(exp_w[95:64]));
          checkOutput("write_data", 256'(bmem_wdata), 256'(exp_w[63:0]));
        end
      end
      if (bmem_read && bmem_ready) begin
        if (cq.size() == 0) reportUnexpected("read_cmd");
        else begin
          exp_c = cq.pop_front();
          checkOutput("read_cmd_addr", 256'(bmem_addr), 256'(exp_c));
        end
      end
      if (dfp_resp) begin
        if (rq.size() == 0) reportUnexpected("dfp_resp");
        else begin
          exp_r = rq.pop_front();
          checkOutput("resp_rdata", dfp_rdata, exp_r);
        end
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [255:0] wdata);
    dfp_write = wr;
    dfp_read  = rd;
    dfp_addr  = addr;
    dfp_wdata = wdata;
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [255:0] line, input int nbeats);
    for (int k = 0; k < nbeats; k++) wq.push_back({addr, line[k*64 +: 64]});
  endtask

  // Returns 1ns after the negedge on which dfp_resp is seen.
  task automatic waitResp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (dfp_resp) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no dfp_resp expected one within 60 cycles", tag);
    end
    #1;
  endtask

  // Returns 1ns after the edge that accepted the read command, i.e. in READ_WAIT.
  task automatic waitCmd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bmem_read && bmem_ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no read command expected one within 60 cycles", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic driveBeat(input logic v, input logic [31:0] ra, input logic [63:0] d);
    bmem_rvalid = v;
    bmem_raddr  = ra;
    bmem_rdata  = d;
    @(posedge clk);
    #1;
    bmem_rvalid = 1'b0;
  endtask

  task automatic driveLine(input logic [31:0] ra, input logic [255:0] line);
    for (int k = 0; k < 4; k++) driveBeat(1'b1, ra, line[k*64 +: 64]);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_bmem_write"}, 256'(bmem_write), 256'(0));
    checkOutput({tag, "_bmem_read"},  256'(bmem_read),  256'(0));
    checkOutput({tag, "_dfp_resp"},   256'(dfp_resp),   256'(0));
    checkOutput({tag, "_bmem_addr"},  256'(bmem_addr),  256'(0));
    checkOutput({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'(0));
    checkOutput({tag, "_dfp_rdata"},  dfp_rdata,        256'(0));
  endtask

  logic [255:0] line_a = {64'hAAAA_0003_0000_0003, 64'hAAAA_0002_0000_0002,
                          64'hAAAA_0001_0000_0001, 64'hAAAA_0000_0000_0000};
  logic [255:0] line_b = {64'hBBBB_0003_1111_0003, 64'hBBBB_0002_1111_0002,
                          64'hBBBB_0001_1111_0001, 64'hBBBB_0000_1111_0000};
  logic [255:0] line_c = {64'hCCCC_0003_2222_0003, 64'hCCCC_0002_2222_0002,
                          64'hCCCC_0001_2222_0001, 64'hCCCC_0000_2222_0000};
  logic [255:0] line_d = {64'hDDDD_0003_3333_0003, 64'hDDDD_0002_3333_0002,
                          64'hDDDD_0001_3333_0001, 64'hDDDD_0000_3333_0000};
  logic [255:0] line_e = {64'hEEEE_0003_4444_0003, 64'hEEEE_0002_4444_0002,
                          64'hEEEE_0001_4444_0001, 64'hEEEE_0000_4444_0000};

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    // Reset state: all outputs quiet while rst is low.
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");

    // Writeback with ready held high; low address bits must be dropped.
    expectWrite(32'h1234_5660, line_a, 4);
    rq.push_back('0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, line_a);
    waitResp("write_ready");
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Writeback with ready toggling: each beat must be held until accepted.
    ready_toggle = 1'b1;
    expectWrite(32'h0000_1000, line_b, 4);
    rq.push_back('0);
    applyStimulus(1'b1, 1'b0, 32'h0000_101F, line_b);
    waitResp("write_toggle");
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    ready_toggle = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Fill at 0x40 with a foreign beat (raddr 0x80) and an rvalid gap interleaved.
    cq.push_back(32'h0000_0040);
    rq.push_back(line_b);
    applyStimulus(1'b0, 1'b1, 32'h0000_0047, '0);
    waitCmd("read_0x40");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFE0, line_e);
    driveBeat(1'b1, 32'h0000_0040, line_b[63:0]);
    driveBeat(1'b1, 32'h0000_0040, line_b[127:64]);
    driveBeat(1'b1, 32'h0000_0080, 64'hDEAD_BEEF_DEAD_BEEF);
    driveBeat(1'b0, 32'h0000_0040, 64'h0BAD_0BAD_0BAD_0BAD);
    driveBeat(1'b1, 32'h0000_0040, line_b[191:128]);
    driveBeat(1'b1, 32'h0000_0040, line_b[255:192]);
    waitResp("read_0x40");
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Writeback then fill on the very next cycle.
    expectWrite(32'h0000_2000, line_c, 4);
    rq.push_back('0);
    cq.push_back(32'h0000_3000);
    rq.push_back(line_d);
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, line_c);
    waitResp("wb_then_fill_wr");
    applyStimulus(1'b0, 1'b1, 32'h0000_3004, '0);
    waitCmd("wb_then_fill_cmd");
    driveLine(32'h0000_3000, line_d);
    waitResp("wb_then_fill_rd");
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted while beat 1 of a writeback is on the bus.
    expectWrite(32'h0000_4000, line_e, 2);
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, line_e);
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkIdleOutputs("midburst_reset");
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    repeat (3) @(negedge clk);
    checkIdleOutputs("held_reset");
    cq.push_back(32'h0000_5000);
    rq.push_back(line_a);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0000_5000, '0);
    waitCmd("post_reset_read");
    driveLine(32'h0000_5000, line_a);
    waitResp("post_reset_read");
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Read and write together: write wins, the still-held read follows.
    expectWrite(32'h0000_0100, line_c, 4);
    rq.push_back('0);
    cq.push_back(32'h0000_0100);
    rq.push_back(line_e);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, line_c);
    waitResp("both_wr");
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, '0);
    waitCmd("both_rd_cmd");
    driveLine(32'h0000_0100, line_e);
    waitResp("both_rd");
    applyStimulus(1'b0, 1'b0, 32'h0, '0);

    repeat (5) @(negedge clk);
    checkOutput("pending_write_beats", 256'(wq.size()), 256'(0));
    checkOutput("pending_read_cmds",   256'(cq.size()), 256'(0));
    checkOutput("pending_responses",   256'(rq.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
